regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: the ALU result path and the load (LSU) result path.
- Tracks outstanding destination registers in a scoreboard so decode can detect RAW/WAW hazards.
- Sits between execute/memory stages and the register file; drives its write address/data/enable from registers.
- Starvation-bounded fixed priority, LSU preferred.

Parameters:
- DATA_WIDTH, 32, write-data width.
- REG_COUNT, 32, number of architectural registers; address width is clog2(REG_COUNT).
- MAX_WAIT, 4, cycles an ALU request may be stalled before ALU gets priority (1..15).

Ports:
- clk_i  in  1  clock.
- reset_l_i  in  1  reset, asynchronous, active-low.
- alu_valid_i  in  1  ALU write-back request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- alu_rd_i  in  AW  ALU destination register.
- alu_data_i  in  DATA_WIDTH  ALU result.
- lsu_valid_i  in  1  LSU write-back request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_rd_i  in  AW  LSU destination register.
- lsu_data_i  in  DATA_WIDTH  load result.
- issue_valid_i  in  1  decode issuing an instruction that writes issue_rd_i.
- issue_rd_i  in  AW  destination of the issuing instruction.
- issue_ready_o  out  1  issue allowed (no WAW).
- rs1_addr_i, rs2_addr_i  in  AW  decode source registers.
- rs1_busy_o, rs2_busy_o  out  1  source has a pending write.
- rf_we_o  out  1  register-file write enable.
- rf_addr_o  out  AW  register-file write address.
- rf_data_o  out  DATA_WIDTH  register-file write data.

Behaviour:
- Reset (async, reset_l_i=0):
  - rf_we_o=0, rf_addr_o=0, rf_data_o=0.
  - Scoreboard all 0, wait counter 0, state PRIO_LSU.
  - Reset mid-operation discards any in-flight write and all pending bits.
- Handshake: a transfer occurs when valid and ready are both 1 at a rising edge. Ready is combinational from state and valids; the output register always drains, so a grant is never stalled.
- State machine (2 states):
  - PRIO_LSU: lsu_ready_o=1; alu_ready_o=!lsu_valid_i.
  - PRIO_ALU: alu_ready_o=1; lsu_ready_o=!alu_valid_i.
  - PRIO_LSU -> PRIO_ALU when alu_valid_i && !alu_ready_o && wait_cnt==MAX_WAIT-1.
  - PRIO_ALU -> PRIO_LSU on an ALU transfer or when alu_valid_i=0.
- Wait counter:
  - Increments when ALU is stalled.
  - Clears on an ALU transfer or alu_valid_i=0.
  - Saturates at MAX_WAIT-1.
- Write port, 1-cycle latency: the transfer at edge N drives rf_we_o/addr/data during cycle N+1 (committed by the register file at edge N+1). With no transfer, rf_we_o=0 and addr/data hold their previous values.
- x0: a transfer with rd=0 completes the handshake but leaves rf_we_o=0. The scoreboard bit for x0 is never set; rs*_busy_o for address 0 is always 0.
- Scoreboard (REG_COUNT bits):
  - Set on issue_valid_i && issue_ready_o with issue_rd_i!=0.
  - Cleared at the edge where rf_we_o=1 for that address.
  - Simultaneous set and clear of the same bit: set wins.
- issue_ready_o=!sb[issue_rd_i] (x0 always ready). Combinational; independent of issue_valid_i.
- rs1_busy_o=sb[rs1_addr_i], rs2_busy_o=sb[rs2_addr_i], read from registered state, combinational lookup.
- A write-back to a register whose bit is clear is still written; the bit stays clear.

Optional Feature:
- Macro REGFILE_WB_FORWARD_EN.
- Defined: adds outputs rs1_fwd_o/rs2_fwd_o (1) and fwd_data_o (DATA_WIDTH).
  - rsN_fwd_o=1 when rf_we_o=1, rf_addr_o==rsN_addr_i and the address is nonzero.
  - fwd_data_o=rf_data_o.
  - rsN_busy_o is masked to 0 when rsN_fwd_o=1.
- Undefined: no extra ports; busy reflects the scoreboard only.

Decomposition:
- Shared package: state encoding (PRIO_LSU=0, PRIO_ALU=1), address-width constant derived from REG_COUNT, x0 index constant.
- One sub-module, wb_scoreboard: bit vector with set/clear ports and two lookup ports. The arbiter FSM, counter and output register stay in the top level.

Test Plan:
- Reset with reset_l_i=0 mid-write -> rf_we_o=0 immediately (async); all busy=0; after release, state PRIO_LSU.
- ALU only, rd=5, data=0xDEADBEEF -> alu_ready_o=1; next cycle rf_we_o=1, addr=5, data=0xDEADBEEF.
- Both valid every cycle, MAX_WAIT=4 -> LSU granted 4 cycles, ALU granted on the 5th; pattern repeats; ALU never waits more than 4 cycles.
- Issue rd=7 -> rs1_busy_o=1 for rs1=7 and issue_ready_o=0 for rd=7; LSU write-back rd=7 -> busy clears the edge after rf_we_o=1.
- Issue rd=0 and ALU write-back rd=0 -> handshake completes, rf_we_o stays 0, busy for 0 stays 0.
- Same-edge clear of rd=9 (rf_we_o=1, addr=9) and issue rd=9 -> busy for 9 remains 1; with REGFILE_WB_FORWARD_EN, rs2=9 in that cycle gives rs2_fwd_o=1 and busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared encodings and constants for the register-file write-back arbiter.
// The optional forwarding outputs are controlled by the REGFILE_WB_FORWARD_EN macro.
package regfile_wb_arbiter_pkg;

    typedef enum logic {
        PrioLsu = 1'b0,
        PrioAlu = 1'b1
    } arb_state_e;

    localparam int unsigned X0_IDX = 0;
    // Wide enough for MAX_WAIT up to 15.
    localparam int unsigned WAIT_W = 4;

    function automatic int unsigned addr_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with one set port,
// one clear port and two lookup ports. The bit for x0 is never set.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned AW        = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic [AW-1:0]        lookup_a_addr,
    input  logic [AW-1:0]        lookup_b_addr,
    output logic                 lookup_a_busy,
    output logic                 lookup_b_busy,
    output logic [REG_COUNT-1:0] pending
);

    logic [REG_COUNT-1:0] sb_d;
    logic [REG_COUNT-1:0] sb_q;

    // Set is applied after clear so a same-edge set of the same register wins.
    always_comb begin
        sb_d = sb_q;
        for (int i = 1; i < int'(REG_COUNT); i++) begin
            if (clr_en && clr_addr == AW'(i)) begin
                sb_d[i] = 1'b0;
            end
            if (set_en && set_addr == AW'(i)) begin
                sb_d[i] = 1'b1;
            end
        end
        sb_d[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign lookup_a_busy = sb_q[lookup_a_addr];
    assign lookup_b_busy = sb_q[lookup_b_addr];
    assign pending       = sb_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU write-back, LSU
// preferred with a bounded ALU wait; optional forwarding via REGFILE_WB_FORWARD_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned MAX_WAIT   = 4,
    localparam int unsigned AW        = addr_width(REG_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  reset_l_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [AW-1:0]         alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [AW-1:0]         lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  issue_valid_i,
    input  logic [AW-1:0]         issue_rd_i,
    output logic                  issue_ready_o,
    input  logic [AW-1:0]         rs1_addr_i,
    input  logic [AW-1:0]         rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
`ifdef REGFILE_WB_FORWARD_EN
    output logic                  rs1_fwd_o,
    output logic                  rs2_fwd_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
`endif
    output logic                  rf_we_o,
    output logic [AW-1:0]         rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_data_o
);

    localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MAX_WAIT - 1);
    localparam logic [AW-1:0]     X0Addr    = AW'(X0_IDX);

    arb_state_e            state_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic                  rf_we_q;
    logic [AW-1:0]         rf_addr_q;
    logic [DATA_WIDTH-1:0] rf_data_q;

    logic                  alu_xfer;
    logic                  lsu_xfer;
    logic                  alu_stall;
    logic                  wb_xfer;
    logic [AW-1:0]         wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  sb_set;
    logic                  sb_rs1_busy;
    logic                  sb_rs2_busy;
    logic [REG_COUNT-1:0]  sb_pending;

    // The two transfers are mutually exclusive by construction of the ready terms.
    always_comb begin
        alu_ready_o = (state_q == PrioAlu) || !lsu_valid_i;
        lsu_ready_o = (state_q == PrioLsu) || !alu_valid_i;
        alu_xfer    = alu_valid_i && alu_ready_o;
        lsu_xfer    = lsu_valid_i && lsu_ready_o;
        alu_stall   = alu_valid_i && !alu_ready_o;
        wb_xfer     = alu_xfer || lsu_xfer;
        wb_rd       = lsu_xfer ? lsu_rd_i : alu_rd_i;
        wb_data     = lsu_xfer ? lsu_data_i : alu_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            state_q    <= PrioLsu;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            case (state_q)
                PrioLsu: begin
                    if (alu_stall && wait_cnt_q == WaitLimit) begin
                        state_q <= PrioAlu;
                    end
                end
                PrioAlu: begin
                    if (alu_xfer || !alu_valid_i) begin
                        state_q <= PrioLsu;
                    end
                end
                default: state_q <= PrioLsu;
            endcase

            if (alu_xfer || !alu_valid_i) begin
                wait_cnt_q <= '0;
            end else if (alu_stall && wait_cnt_q != WaitLimit) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end

            // x0 write-backs handshake normally but never assert the write enable.
            rf_we_q <= wb_xfer && (wb_rd != X0Addr);
            if (wb_xfer) begin
                rf_addr_q <= wb_rd;
                rf_data_q <= wb_data;
            end
        end
    end

    assign issue_ready_o = !sb_pending[issue_rd_i];
    assign sb_set        = issue_valid_i && issue_ready_o && (issue_rd_i != X0Addr);

    wb_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .AW        (AW)
    ) u_scoreboard (
        .clk           (clk_i),
        .rst_n         (reset_l_i),
        .set_en        (sb_set),
        .set_addr      (issue_rd_i),
        .clr_en        (rf_we_q),
        .clr_addr      (rf_addr_q),
        .lookup_a_addr (rs1_addr_i),
        .lookup_b_addr (rs2_addr_i),
        .lookup_a_busy (sb_rs1_busy),
        .lookup_b_busy (sb_rs2_busy),
        .pending       (sb_pending)
    );

    assign rf_we_o   = rf_we_q;
    assign rf_addr_o = rf_addr_q;
    assign rf_data_o = rf_data_q;

`ifdef REGFILE_WB_FORWARD_EN
    assign rs1_fwd_o  = rf_we_q && (rf_addr_q == rs1_addr_i) && (rs1_addr_i != X0Addr);
    assign rs2_fwd_o  = rf_we_q && (rf_addr_q == rs2_addr_i) && (rs2_addr_i != X0Addr);
    assign fwd_data_o = rf_data_q;
    assign rs1_busy_o = sb_rs1_busy && !rs1_fwd_o;
    assign rs2_busy_o = sb_rs2_busy && !rs2_fwd_o;
`else
    assign rs1_busy_o = sb_rs1_busy;
    assign rs2_busy_o = sb_rs2_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter (default parameters, MAX_WAIT=4).
// Forwarding outputs are checked only when REGFILE_WB_FORWARD_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_l_i;
    logic        alu_valid_i, lsu_valid_i, issue_valid_i;
    logic        alu_ready_o, lsu_ready_o, issue_ready_o;
    logic [4:0]  alu_rd_i, lsu_rd_i, issue_rd_i, rs1_addr_i, rs2_addr_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        rs1_busy_o, rs2_busy_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
`ifdef REGFILE_WB_FORWARD_EN
    logic        rs1_fwd_o, rs2_fwd_o;
    logic [31:0] fwd_data_o;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk_i         (clk),
        .reset_l_i     (reset_l_i),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
`ifdef REGFILE_WB_FORWARD_EN
        .rs1_fwd_o     (rs1_fwd_o),
        .rs2_fwd_o     (rs2_fwd_o),
        .fwd_data_o    (fwd_data_o),
`endif
        .rf_we_o       (rf_we_o),
        .rf_addr_o     (rf_addr_o),
        .rf_data_o     (rf_data_o)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ar;
        logic        lr;
        logic        ir;
        logic        b1;
        logic        b2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        f2;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic ar, input logic lr, input logic ir,
                       input logic b1, input logic b2,
                       input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic f2);
        vec_t v;
        v = '{av, ard, adat, lv, lrd, ldat, iv, ird, rs1, rs2,
              ar, lr, ir, b1, b2, we, waddr, wdata, f2};
        vq.push_back(v);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        alu_valid_i   = av;
        alu_rd_i      = ard;
        alu_data_i    = adat;
        lsu_valid_i   = lv;
        lsu_rd_i      = lrd;
        lsu_data_i    = ldat;
        issue_valid_i = iv;
        issue_rd_i    = ird;
        rs1_addr_i    = rs1;
        rs2_addr_i    = rs2;
    endtask

    initial begin
        reset_l_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //  av ard adat          lv lrd ldat         iv ird rs1 rs2 | ar lr ir b1 b2 we wa wdata    f2
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 0
        add(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 1
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,   1, 1, 1, 0, 0, 1, 5, 32'hDEADBEEF, 0);
        add(0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 7, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 3
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 7, 7, 7,   1, 1, 0, 1, 1, 0, 0, 32'h0, 0);
        add(0, 0, 32'h0,        1, 7, 32'h11112222, 0, 7, 7, 0,   0, 1, 0, 1, 0, 0, 0, 32'h0, 0); // 5
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 7, 7, 0,   1, 1, 0, 1, 0, 1, 7, 32'h11112222, 0);
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 7, 7, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 7
        add(1, 0, 32'h0000AAAA, 0, 0, 32'h0,        1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0, 0);
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 9
        // Both requesters every cycle: LSU x4, then ALU, repeating.
        add(1, 1, 32'hA0000010, 1, 2, 32'hB0000010, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 10
        add(1, 1, 32'hA0000011, 1, 2, 32'hB0000011, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 2, 32'hB0000010, 0);
        add(1, 1, 32'hA0000012, 1, 2, 32'hB0000012, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 2, 32'hB0000011, 0);
        add(1, 1, 32'hA0000013, 1, 2, 32'hB0000013, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 2, 32'hB0000012, 0);
        add(1, 1, 32'hA0000014, 1, 2, 32'hB0000014, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 2, 32'hB0000013, 0);
        add(1, 1, 32'hA0000015, 1, 2, 32'hB0000015, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 1, 32'hA0000014, 0);
        add(1, 1, 32'hA0000016, 1, 2, 32'hB0000016, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 2, 32'hB0000015, 0);
        add(1, 1, 32'hA0000017, 1, 2, 32'hB0000017, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 2, 32'hB0000016, 0);
        add(1, 1, 32'hA0000018, 1, 2, 32'hB0000018, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 2, 32'hB0000017, 0);
        add(1, 1, 32'hA0000019, 1, 2, 32'hB0000019, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 2, 32'hB0000018, 0);
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 2,   1, 1, 1, 0, 0, 1, 1, 32'hA0000019, 0);
        // Write-back to a clear bit, then issue of the same register on its write cycle.
        add(0, 0, 32'h0,        1, 9, 32'h00000099, 0, 0, 0, 9,   0, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 21
        add(0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 0, 9,   1, 1, 1, 0, 0, 1, 9, 32'h00000099, 1);
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 9, 0, 9,   1, 1, 0, 0, 1, 0, 0, 32'h0, 0); // 23
        // ALU drops after two stalls: the wait count restarts from zero.
        add(1, 3, 32'hA0000024, 1, 4, 32'hB0000024, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 32'h0, 0); // 24
        add(1, 3, 32'hA0000025, 1, 4, 32'hB0000025, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 4, 32'hB0000024, 0);
        add(0, 3, 32'hA0000026, 1, 4, 32'hB0000026, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 4, 32'hB0000025, 0);
        add(1, 3, 32'hA0000027, 1, 4, 32'hB0000027, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 4, 32'hB0000026, 0);
        add(1, 3, 32'hA0000028, 1, 4, 32'hB0000028, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 4, 32'hB0000027, 0);
        add(1, 3, 32'hA0000029, 1, 4, 32'hB0000029, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 4, 32'hB0000028, 0);
        add(1, 3, 32'hA0000030, 1, 4, 32'hB0000030, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 4, 32'hB0000029, 0);
        add(1, 3, 32'hA0000031, 1, 4, 32'hB0000031, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 4, 32'hB0000030, 0);
        add(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 0,   1, 1, 1, 1, 0, 1, 3, 32'hA0000031, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset.rf_we", rf_we_o, 1'b0);
        check("reset.rf_addr", rf_addr_o, 5'd0);
        check("reset.rf_data", rf_data_o, 32'h0);
        reset_l_i = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].av, vq[i].ard, vq[i].adat, vq[i].lv, vq[i].lrd, vq[i].ldat,
                  vq[i].iv, vq[i].ird, vq[i].rs1, vq[i].rs2);
            #2;
            check($sformatf("v%0d.alu_ready", i), alu_ready_o, vq[i].ar);
            check($sformatf("v%0d.lsu_ready", i), lsu_ready_o, vq[i].lr);
            check($sformatf("v%0d.issue_ready", i), issue_ready_o, vq[i].ir);
            check($sformatf("v%0d.rs1_busy", i), rs1_busy_o, vq[i].b1);
            check($sformatf("v%0d.rs2_busy", i), rs2_busy_o, vq[i].b2);
            check($sformatf("v%0d.rf_we", i), rf_we_o, vq[i].we);
            if (vq[i].we) begin
                check($sformatf("v%0d.rf_addr", i), rf_addr_o, vq[i].waddr);
                check($sformatf("v%0d.rf_data", i), rf_data_o, vq[i].wdata);
            end
`ifdef REGFILE_WB_FORWARD_EN
            check($sformatf("v%0d.rs2_fwd", i), rs2_fwd_o, vq[i].f2);
            if (vq[i].f2) begin
                check($sformatf("v%0d.fwd_data", i), fwd_data_o, vq[i].wdata);
            end
`endif
        end

        // ALU wins after four stalls, then drops its request while holding priority.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 3, 32'h1, 1, 4, 32'h2, 0, 0, 0, 0);
            #2;
            check($sformatf("prio.stall%0d", k), alu_ready_o, 1'b0);
        end
        @(negedge clk);
        drive(0, 3, 32'h1, 1, 4, 32'h2, 0, 0, 0, 0);
        #2;
        check("prio.alu_state_alu_ready", alu_ready_o, 1'b1);
        check("prio.alu_state_lsu_ready", lsu_ready_o, 1'b1);
        @(negedge clk);
        drive(1, 3, 32'h1, 1, 4, 32'h2, 0, 0, 0, 0);
        #2;
        check("prio.back_to_lsu_alu", alu_ready_o, 1'b0);
        check("prio.back_to_lsu_lsu", lsu_ready_o, 1'b1);

        // Asynchronous reset while a write is on the port and a register is pending.
        @(negedge clk);
        drive(1, 6, 32'h00000066, 0, 0, 32'h0, 1, 12, 12, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 12, 0);
        #1;
        check("midrst.pre_we", rf_we_o, 1'b1);
        check("midrst.pre_busy", rs1_busy_o, 1'b1);
        reset_l_i = 1'b0;
        #1;
        check("midrst.we", rf_we_o, 1'b0);
        check("midrst.addr", rf_addr_o, 5'd0);
        check("midrst.data", rf_data_o, 32'h0);
        check("midrst.busy", rs1_busy_o, 1'b0);
        @(negedge clk);
        reset_l_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 3, 32'h1, 1, 4, 32'h2, 0, 0, 0, 0);
            #2;
            check($sformatf("postrst.alu_ready%0d", k), alu_ready_o, (k == 4) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
